// File: rtl/sm_mem_msgs_pkg.sv
// Standard mem request/response message definitions: type codes, field widths and field offsets.
// Request and response share the layout {type, opaque, addr, len, data}, MSB to LSB.
package sm_mem_msgs_pkg;

    localparam logic [2:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] MEM_TYPE_WRITE_INIT = 3'd2;
    localparam logic [2:0] MEM_TYPE_AMO_ADD    = 3'd3;
    localparam logic [2:0] MEM_TYPE_AMO_AND    = 3'd4;
    localparam logic [2:0] MEM_TYPE_AMO_OR     = 3'd5;

    localparam int TYPE_NBITS = 3;
    localparam int DATA_LSB   = 0;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_WAIT,
        PORT_RESP
    } port_state_e;

    function automatic int len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int req_nbits(input int o, input int a, input int d);
        return TYPE_NBITS + o + a + len_nbits(d) + d;
    endfunction

    function automatic int resp_nbits(input int o, input int a, input int d);
        return TYPE_NBITS + o + a + len_nbits(d) + d;
    endfunction

    function automatic int len_lsb(input int d);
        return DATA_LSB + d;
    endfunction

    function automatic int addr_lsb(input int d);
        return len_lsb(d) + len_nbits(d);
    endfunction

    function automatic int opaque_lsb(input int a, input int d);
        return addr_lsb(d) + a;
    endfunction

    function automatic int type_lsb(input int o, input int a, input int d);
        return opaque_lsb(a, d) + o;
    endfunction

endpackage

// File: rtl/sm_test_mem_port_ctrl.sv
// One port of the N-port test memory: IDLE/WAIT/RESP FSM, latency counter, response register,
// and the byte-lane write request for the shared array. SM_TEST_MEM_RAND_DELAY_EN adds an LFSR jitter.
module sm_test_mem_port_ctrl
    import sm_mem_msgs_pkg::*;
#(
`ifdef SM_TEST_MEM_RAND_DELAY_EN
    parameter logic [15:0] p_lfsr_seed = 16'd1,
`endif
    parameter int p_mem_nbytes   = 1024,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_latency      = 0,
    localparam int REQ_NBITS     = req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int RESP_NBITS    = resp_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int BLK_BYTES     = p_data_nbits / 8,
    localparam int OFF_NBITS     = $clog2(BLK_BYTES),
    localparam int BADDR_NBITS   = $clog2(p_mem_nbytes),
    localparam int BLK_NBITS     = BADDR_NBITS - OFF_NBITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memreq_val_i,
    output logic                    memreq_rdy_o,
    input  logic [REQ_NBITS-1:0]    memreq_msg_i,
    output logic                    memresp_val_o,
    input  logic                    memresp_rdy_i,
    output logic [RESP_NBITS-1:0]   memresp_msg_o,
    output logic [BLK_NBITS-1:0]    blk_idx_o,
    input  logic [p_data_nbits-1:0] blk_rdata_i,
    output logic                    wr_en_o,
    output logic [BLK_BYTES-1:0]    wr_mask_o,
    output logic [p_data_nbits-1:0] wr_data_o
);

    localparam int LEN_NBITS = len_nbits(p_data_nbits);

    port_state_e             state_q, state_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [RESP_NBITS-1:0]   resp_q, resp_d;
    logic [8:0]              delay;

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [LEN_NBITS-1:0]      req_len;
    logic [p_data_nbits-1:0]   req_data;

    logic                      req_fire, resp_fire, is_write, is_amo;
    logic [OFF_NBITS-1:0]      offset;
    logic [OFF_NBITS+2:0]      shamt;
    logic [OFF_NBITS:0]        nbytes;
    logic [BLK_BYTES-1:0]      len_mask;
    logic [p_data_nbits-1:0]   old_data, operand, resp_data;

    assign req_type   = memreq_msg_i[type_lsb(p_opaque_nbits, p_addr_nbits, p_data_nbits) +: TYPE_NBITS];
    assign req_opaque = memreq_msg_i[opaque_lsb(p_addr_nbits, p_data_nbits) +: p_opaque_nbits];
    assign req_addr   = memreq_msg_i[addr_lsb(p_data_nbits) +: p_addr_nbits];
    assign req_len    = memreq_msg_i[len_lsb(p_data_nbits) +: LEN_NBITS];
    assign req_data   = memreq_msg_i[DATA_LSB +: p_data_nbits];

    assign memreq_rdy_o  = reset && ((state_q == PORT_IDLE) || ((state_q == PORT_RESP) && memresp_rdy_i));
    assign memresp_val_o = reset && (state_q == PORT_RESP);
    assign memresp_msg_o = resp_q;
    assign req_fire      = memreq_val_i && memreq_rdy_o;
    assign resp_fire     = memresp_val_o && memresp_rdy_i;

    assign offset    = req_addr[OFF_NBITS-1:0];
    assign blk_idx_o = req_addr[BADDR_NBITS-1:OFF_NBITS];
    assign shamt     = {offset, 3'b000};
    assign old_data  = blk_rdata_i >> shamt;
    assign nbytes    = (req_len == '0) ? (OFF_NBITS + 1)'(BLK_BYTES) : {1'b0, req_len};

    assign is_write  = (req_type == MEM_TYPE_WRITE) || (req_type == MEM_TYPE_WRITE_INIT);
    assign is_amo    = (req_type == MEM_TYPE_AMO_ADD) || (req_type == MEM_TYPE_AMO_AND) ||
                       (req_type == MEM_TYPE_AMO_OR);
    assign resp_data = is_write ? '0 : old_data;

    // Lanes shifted past the top of the block fall off the mask and are dropped.
    always_comb begin
        for (int j = 0; j < BLK_BYTES; j++) begin
            len_mask[j] = ((OFF_NBITS + 1)'(j) < nbytes);
        end
    end

    always_comb begin
        case (req_type)
            MEM_TYPE_AMO_ADD: operand = old_data + req_data;
            MEM_TYPE_AMO_AND: operand = old_data & req_data;
            MEM_TYPE_AMO_OR:  operand = old_data | req_data;
            default:          operand = req_data;
        endcase
    end

    assign wr_en_o   = req_fire && (is_write || is_amo);
    assign wr_mask_o = len_mask << offset;
    assign wr_data_o = operand << shamt;

`ifdef SM_TEST_MEM_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign delay  = 9'(p_latency) + {7'd0, lfsr_q[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) lfsr_q <= p_lfsr_seed;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign delay = 9'(p_latency);
`endif

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            PORT_WAIT: begin
                cnt_d = cnt_q - 9'd1;
                if (cnt_q == 9'd1) state_d = PORT_RESP;
            end
            PORT_RESP: if (resp_fire) state_d = PORT_IDLE;
            default: ;
        endcase
        // A new accept overrides the RESP->IDLE return so the port can stream one request per cycle.
        if (req_fire) begin
            resp_d = {req_type, req_opaque, req_addr, req_len, resp_data};
            if (delay == 9'd0) begin
                state_d = PORT_RESP;
                cnt_d   = 9'd0;
            end else begin
                state_d = PORT_WAIT;
                cnt_d   = delay;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PORT_IDLE;
            cnt_q   <= 9'd0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) req_fire |-> (req_type <= MEM_TYPE_AMO_OR));

endmodule

// File: rtl/sm_test_mem_nport.sv
// N-port test memory: per-port controllers share one byte array; same-cycle writes resolve with the
// highest port index winning. Optional build macro SM_TEST_MEM_RAND_DELAY_EN adds random per-port latency.
module sm_test_mem_nport
    import sm_mem_msgs_pkg::*;
#(
    parameter int p_num_ports    = 2,
    parameter int p_mem_nbytes   = 1024,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_latency      = 0,
    localparam int REQ_NBITS     = req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int RESP_NBITS    = resp_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_clear,
    input  logic [p_num_ports-1:0]            memreq_val,
    output logic [p_num_ports-1:0]            memreq_rdy,
    input  logic [p_num_ports*REQ_NBITS-1:0]  memreq_msg,
    output logic [p_num_ports-1:0]            memresp_val,
    input  logic [p_num_ports-1:0]            memresp_rdy,
    output logic [p_num_ports*RESP_NBITS-1:0] memresp_msg
);

    localparam int BLK_BYTES   = p_data_nbits / 8;
    localparam int OFF_NBITS   = $clog2(BLK_BYTES);
    localparam int BADDR_NBITS = $clog2(p_mem_nbytes);
    localparam int BLK_NBITS   = BADDR_NBITS - OFF_NBITS;

    logic [7:0] mem_q [p_mem_nbytes];

    logic [p_num_ports-1:0][BLK_NBITS-1:0]    blk_idx;
    logic [p_num_ports-1:0][p_data_nbits-1:0] blk_rdata;
    logic [p_num_ports-1:0]                   wr_en;
    logic [p_num_ports-1:0][BLK_BYTES-1:0]    wr_mask;
    logic [p_num_ports-1:0][p_data_nbits-1:0] wr_data;

    for (genvar g = 0; g < p_num_ports; g++) begin : g_port
        sm_test_mem_port_ctrl #(
`ifdef SM_TEST_MEM_RAND_DELAY_EN
            .p_lfsr_seed    (16'(g + 1)),
`endif
            .p_mem_nbytes   (p_mem_nbytes),
            .p_opaque_nbits (p_opaque_nbits),
            .p_addr_nbits   (p_addr_nbits),
            .p_data_nbits   (p_data_nbits),
            .p_latency      (p_latency)
        ) u_ctrl (
            .clk           (clk),
            .reset         (reset),
            .memreq_val_i  (memreq_val[g]),
            .memreq_rdy_o  (memreq_rdy[g]),
            .memreq_msg_i  (memreq_msg[g*REQ_NBITS +: REQ_NBITS]),
            .memresp_val_o (memresp_val[g]),
            .memresp_rdy_i (memresp_rdy[g]),
            .memresp_msg_o (memresp_msg[g*RESP_NBITS +: RESP_NBITS]),
            .blk_idx_o     (blk_idx[g]),
            .blk_rdata_i   (blk_rdata[g]),
            .wr_en_o       (wr_en[g]),
            .wr_mask_o     (wr_mask[g]),
            .wr_data_o     (wr_data[g])
        );
    end

    // Every port reads the pre-edge contents, so reads never observe same-cycle writes.
    always_comb begin
        for (int p = 0; p < p_num_ports; p++) begin
            for (int b = 0; b < BLK_BYTES; b++) begin
                blk_rdata[p][b*8 +: 8] = mem_q[{blk_idx[p], OFF_NBITS'(b)}];
            end
        end
    end

    // NOTE: the array has no reset; a backing store keeps its contents and only mem_clear zeroes it.
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int a = 0; a < p_mem_nbytes; a++) begin
                mem_q[a] <= 8'h00;
            end
        end else begin
            // Later iterations override earlier ones, giving the highest port index priority.
            for (int p = 0; p < p_num_ports; p++) begin
                for (int b = 0; b < BLK_BYTES; b++) begin
                    if (wr_en[p] && wr_mask[p][b]) begin
                        mem_q[{blk_idx[p], OFF_NBITS'(b)}] <= wr_data[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !$isunknown(memreq_val));
    assert property (@(posedge clk) disable iff (!reset) !$isunknown(memresp_rdy));

endmodule
